mem_trace_buffer: RTL and testbench
===================================

MEM_TRACE_BUFFER -- requirements
Module: mem_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter DEDUP, default 1, meaning suppress a capture identical to the last record pushed.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_addr  input  15  memory address bus from the memory board.
REQ-006 SHALL have port mem_val  input  26  memory data word (two 13-bit syllables).
REQ-007 SHALL have port mem_strobe  input  1  bus sample qualifier; capture candidate when high.
REQ-008 SHALL have port trace_en  input  1  capture enable.
REQ-009 SHALL have port clear  input  1  synchronous flush of FIFO, counters and dedup history.
REQ-010 SHALL have port out_valid  output  1  record available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts record.
REQ-012 SHALL have port out_data  output  41  record {mem_addr[14:0], mem_val[25:0]}.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: at least one record dropped.
REQ-015 SHALL have port drop_count  output  8  dropped records, saturating at 255.

Function
REQ-016 SHALL treat a cycle as a capture when mem_strobe=1 and trace_en=1 and clear=0.
REQ-017 SHALL, with DEDUP=1, discard a capture whose {addr,val} equals the last pushed record; the first capture after reset or clear always qualifies; discards are not drops.
REQ-018 SHALL push a qualifying capture in the same cycle; the record is visible on out_data with out_valid=1 on the following cycle when FIFO was empty (1-cycle latency, first-word-fall-through).
REQ-019 SHALL pop on out_valid=1 and out_ready=1; out_data and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, when full with no pop that cycle, drop the capture, set overflow, increment drop_count (saturating), and leave the dedup history unchanged.
REQ-021 SHALL, when full with a simultaneous pop, accept the push; count stays DEPTH.
REQ-022 SHALL, when empty, ignore out_ready; simultaneous push into empty is not bypassed combinationally.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count = pushes minus pops, 0..DEPTH.
REQ-024 SHALL give clear priority over push and pop: next cycle count=0, out_valid=0, overflow=0, drop_count=0, dedup history invalid.
REQ-025 SHALL freeze capture but continue draining when trace_en falls; history persists across trace_en toggles.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force out_valid=0, count=0, overflow=0, drop_count=0, pointers=0, history invalid; out_data=0.
REQ-027 SHALL discard any in-flight capture when reset asserts mid-operation; first post-release capture is on the first rising edge with rst_n=1.
REQ-028 SHALL not reset FIFO storage RAM (contents undefined, never exposed while out_valid=0).

Structure
REQ-029 SHALL take ADDR_W=15, WORD_W=26, SYL_W=13 and the packed record type from shared package lvdc_trace_pkg.
REQ-030 SHALL place storage and pointers in one sub-module trace_fifo (push, pop, full, empty, count); capture/dedup/overflow logic stays in mem_trace_buffer.

Verification
REQ-031 SHALL cover: reset, single capture addr=0x0123 val=0x2AAAAAA, out_ready=1 -> out_valid one cycle later, out_data=0x0123_2AAAAAA packed, then count=0.
REQ-032 SHALL cover: DEDUP=1, same {0x0010,0x0000001} strobed 5 consecutive cycles then {0x0011,0x0000001} -> exactly 2 records out, drop_count=0.
REQ-033 SHALL cover: out_ready=0, 20 distinct captures into DEPTH=16 -> count=16, overflow=1, drop_count=4, drain yields first 16 records in order.
REQ-034 SHALL cover: full FIFO, push and pop same cycle -> count stays 16, new record appears last, overflow unchanged.
REQ-035 SHALL cover: 300 drops -> drop_count=255; clear for one cycle -> count=0, overflow=0, drop_count=0, next repeated record accepted.
REQ-036 SHALL cover: rst_n pulsed low mid-stream with 7 entries held -> outputs zero immediately (asynchronously), no stale record after release.

Source files
------------

// File: rtl/lvdc_trace_pkg.sv
// Shared widths and the packed trace record for the LVDC memory trace path.
// Field order of trace_rec_t defines the out_data layout {addr, val}.
package lvdc_trace_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned WORD_W = 26;
   localparam int unsigned SYL_W  = 13;
   localparam int unsigned REC_W  = ADDR_W + WORD_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] val;
   } trace_rec_t;

   function automatic trace_rec_t make_rec(input logic [ADDR_W-1:0] a,
                                           input logic [WORD_W-1:0] v);
      trace_rec_t r;
      r.addr = a;
      r.val  = v;
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO with power-of-two depth and a synchronous flush.
// Storage is not reset; pop_rec reads as zero whenever the FIFO is empty.
module trace_fifo
   import lvdc_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  trace_rec_t               push_rec,
   input  logic                     pop,
   output trace_rec_t               pop_rec,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   trace_rec_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign count   = count_q;
   assign pop_rec = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= push_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_trace_buffer.sv
// Memory bus trace capture: qualifies strobed bus samples, suppresses repeats,
// buffers records in trace_fifo and tracks dropped captures when full.
module mem_trace_buffer
   import lvdc_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DEDUP = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [WORD_W-1:0]        mem_val,
   input  logic                     mem_strobe,
   input  logic                     trace_en,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REC_W-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   trace_rec_t cap_rec;
   trace_rec_t hist_rec;
   trace_rec_t head_rec;
   logic       hist_valid;
   logic       capture;
   logic       dup;
   logic       qualify;
   logic       pop;
   logic       push;
   logic       drop;
   logic       full;
   logic       empty;

   assign cap_rec   = make_rec(mem_addr, mem_val);
   assign capture   = mem_strobe & trace_en & ~clear;
   assign dup       = (DEDUP != 0) && hist_valid && (cap_rec == hist_rec);
   assign qualify   = capture & ~dup;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign push      = qualify & (~full | pop);
   assign drop      = qualify & full & ~pop;
   assign out_data  = head_rec;

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (push),
      .push_rec (cap_rec),
      .pop      (pop),
      .pop_rec  (head_rec),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   // History tracks only records that entered the FIFO; drops leave it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_valid <= 1'b0;
         hist_rec   <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         hist_valid <= 1'b0;
         hist_rec   <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) begin
            hist_valid <= 1'b1;
            hist_rec   <= cap_rec;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF)
               drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Directed bench for mem_trace_buffer (DEPTH=16, DEDUP=1) with hand-computed expectations.
module tb_mem_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] mem_addr;
   logic [25:0] mem_val;
   logic        mem_strobe;
   logic        trace_en;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [40:0] out_data;
   logic [4:0]  count;
   logic        overflow;
   logic [7:0]  drop_count;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   mem_trace_buffer #(
      .DEPTH (16),
      .DEDUP (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_val    (mem_val),
      .mem_strobe (mem_strobe),
      .trace_en   (trace_en),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .count      (count),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [40:0] rec(input int unsigned i);
      logic [14:0] a;
      logic [25:0] v;
      a = 15'(32'h100 + i);
      v = 26'(i * 3 + 7);
      return {a, v};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [40:0] r);
      mem_addr = r[40:26];
      mem_val  = r[25:0];
   endtask

   task automatic pop_check(input string tag, input logic [40:0] exp);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   logic [40:0] fresh;

   initial begin
      rst_n = 1'b0; mem_addr = '0; mem_val = '0; mem_strobe = 1'b0;
      trace_en = 1'b1; clear = 1'b0; out_ready = 1'b0;
      #3;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_drops", 64'(drop_count), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      #9 rst_n = 1'b1;
      step();

      // single capture, 1-cycle latency, packed layout
      out_ready = 1'b1;
      mem_addr = 15'h0123; mem_val = 26'h2AAAAAA; mem_strobe = 1'b1;
      step();
      mem_strobe = 1'b0;
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_data", 64'(out_data), 64'h048EAAAAAA);
      step();
      check("single_count", 64'(count), 64'd0);
      check("single_drained", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // dedup of repeated sample
      do_clear();
      mem_strobe = 1'b1;
      drive({15'h0010, 26'h0000001});
      repeat (5) step();
      drive({15'h0011, 26'h0000001});
      step();
      mem_strobe = 1'b0;
      check("dedup_count", 64'(count), 64'd2);
      check("dedup_drops", 64'(drop_count), 64'd0);
      pop_check("dedup_r0", {15'h0010, 26'h0000001});
      pop_check("dedup_r1", {15'h0011, 26'h0000001});
      check("dedup_empty", 64'(out_valid), 64'd0);

      // overflow: 20 distinct captures into 16 entries
      do_clear();
      mem_strobe = 1'b1;
      for (int unsigned i = 0; i < 20; i++) begin
         drive(rec(i));
         step();
      end
      mem_strobe = 1'b0;
      check("ovf_count", 64'(count), 64'd16);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_drops", 64'(drop_count), 64'd4);
      check("ovf_head", 64'(out_data), 64'(rec(0)));

      // full with simultaneous push and pop
      fresh = {15'h07FF, 26'h1234567};
      drive(fresh);
      mem_strobe = 1'b1;
      out_ready = 1'b1;
      step();
      mem_strobe = 1'b0;
      out_ready = 1'b0;
      check("pp_count", 64'(count), 64'd16);
      check("pp_ovf", 64'(overflow), 64'd1);
      check("pp_drops", 64'(drop_count), 64'd4);
      for (int unsigned i = 1; i < 16; i++)
         pop_check($sformatf("drain%0d", i), rec(i));
      pop_check("drain_new", fresh);
      check("drain_count", 64'(count), 64'd0);

      // trace_en low freezes capture
      trace_en = 1'b0;
      mem_strobe = 1'b1;
      drive(rec(77));
      step();
      mem_strobe = 1'b0;
      trace_en = 1'b1;
      check("freeze_count", 64'(count), 64'd0);

      // saturation and clear
      do_clear();
      mem_strobe = 1'b1;
      for (int unsigned i = 0; i < 16; i++) begin
         drive(rec(i));
         step();
      end
      drive(rec(99));
      repeat (300) step();
      check("sat_drops", 64'(drop_count), 64'd255);
      check("sat_ovf", 64'(overflow), 64'd1);
      check("sat_count", 64'(count), 64'd16);
      drive(rec(15));
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_count", 64'(count), 64'd0);
      check("clr_valid", 64'(out_valid), 64'd0);
      check("clr_ovf", 64'(overflow), 64'd0);
      check("clr_drops", 64'(drop_count), 64'd0);
      step();
      check("clr_hist_count", 64'(count), 64'd1);
      check("clr_hist_data", 64'(out_data), 64'(rec(15)));
      step();
      check("clr_redup_count", 64'(count), 64'd1);
      mem_strobe = 1'b0;

      // async reset with 7 entries held
      do_clear();
      mem_strobe = 1'b1;
      for (int unsigned i = 0; i < 7; i++) begin
         drive(rec(200 + i));
         step();
      end
      check("pre_rst_count", 64'(count), 64'd7);
      drive(rec(300));
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_count", 64'(count), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      mem_strobe = 1'b0;
      #1 rst_n = 1'b1;
      step();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_count", 64'(count), 64'd0);
      mem_strobe = 1'b1;
      drive(rec(7));
      step();
      mem_strobe = 1'b0;
      check("post_rst_cap", 64'(out_data), 64'(rec(7)));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
